// File: rtl/mem_region_router.sv
// Registered load/store router: decodes an LSU request against a prioritised
// region table, runs one translated slave access with a timeout, and returns a one-cycle response.
module mem_region_router #(
    parameter int LENGTH   = 32,
    parameter int N_SLAVES = 3,
    parameter logic [N_SLAVES-1:0][LENGTH-1:0] REGION_BASE  = {32'h1004_0000, 32'h1001_0000, 32'h1001_0020},
    parameter logic [N_SLAVES-1:0][LENGTH-1:0] REGION_LIMIT = {32'h7FFF_EFFB, 32'h1003_FFFF, 32'h1001_0038},
    parameter logic [N_SLAVES-1:0][LENGTH-1:0] REGION_XLATE = {32'h7FFF_EF28, 32'h1001_0000, 32'h1001_0020},
    parameter int TIMEOUT  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [LENGTH-1:0]            req_addr,
    input  logic [LENGTH-1:0]            req_wdata,
    input  logic                         req_we,
    input  logic [LENGTH/8-1:0]          req_be,
    output logic                         rsp_valid,
    output logic [LENGTH-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [N_SLAVES-1:0]          s_sel,
    output logic [LENGTH-1:0]            s_addr,
    output logic [LENGTH-1:0]            s_wdata,
    output logic                         s_we,
    output logic [LENGTH/8-1:0]          s_be,
    input  logic [N_SLAVES*LENGTH-1:0]   s_rdata,
    input  logic [N_SLAVES-1:0]          s_ready,
    output logic [1:0]                   dbg_state
);

    // Handshake: a request transfers on a clock edge where req_valid && req_ready;
    // the response is a single rsp_valid cycle and cannot be stalled.

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_cnt;
    logic [N_SLAVES-1:0]    r_s_sel;
    logic [LENGTH-1:0]      r_s_addr;
    logic [LENGTH-1:0]      r_s_wdata;
    logic                   r_s_we;
    logic [LENGTH/8-1:0]    r_s_be;
    logic [LENGTH-1:0]      r_rsp_rdata;
    logic                   r_rsp_err;

    logic                   w_accept;
    logic                   w_hit;
    logic [N_SLAVES-1:0]    w_hit_sel;
    logic [LENGTH-1:0]      w_xlate;
    logic [LENGTH-1:0]      w_xaddr;
    logic                   w_slv_ready;
    logic [LENGTH-1:0]      w_slv_rdata;
    logic                   w_timeout;

    // Lowest matching index wins so overlapping regions resolve by priority.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_sel = '0;
        w_xlate   = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (!w_hit && req_addr >= REGION_BASE[k] && req_addr <= REGION_LIMIT[k]) begin
                w_hit        = 1'b1;
                w_hit_sel[k] = 1'b1;
                w_xlate      = REGION_XLATE[k];
            end
        end
    end

    assign w_xaddr  = (req_addr - w_xlate) >> 2;
    assign w_accept = req_valid && (r_state == ST_IDLE);

    always_comb begin
        w_slv_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (r_s_sel[k]) begin
                w_slv_rdata = w_slv_rdata | s_rdata[k*LENGTH +: LENGTH];
            end
        end
    end

    assign w_slv_ready = |(s_ready & r_s_sel);
    assign w_timeout   = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = w_hit ? ST_ACCESS : ST_RESP;
            ST_ACCESS: if (w_slv_ready || w_timeout) w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == ST_IDLE);
        rsp_valid = (r_state == ST_RESP);
        rsp_rdata = (r_state == ST_RESP) ? r_rsp_rdata : '0;
        rsp_err   = (r_state == ST_RESP) ? r_rsp_err : 1'b0;
        s_sel     = r_s_sel;
        s_addr    = r_s_addr;
        s_wdata   = r_s_wdata;
        s_we      = r_s_we;
        s_be      = r_s_be;
        dbg_state = r_state;
    end

    // Slave-side registers are loaded only on a hit and cleared on leaving ACCESS,
    // so they read zero in IDLE and RESP and a miss never touches a slave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_s_sel     <= '0;
            r_s_addr    <= '0;
            r_s_wdata   <= '0;
            r_s_we      <= 1'b0;
            r_s_be      <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        if (w_hit) begin
                            r_s_sel   <= w_hit_sel;
                            r_s_addr  <= w_xaddr;
                            r_s_wdata <= req_wdata;
                            r_s_we    <= req_we;
                            r_s_be    <= req_be;
                        end else begin
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_slv_ready || w_timeout) begin
                        r_rsp_rdata <= (w_slv_ready && !r_s_we) ? w_slv_rdata : '0;
                        r_rsp_err   <= !w_slv_ready;
                        r_s_sel     <= '0;
                        r_s_addr    <= '0;
                        r_s_wdata   <= '0;
                        r_s_we      <= 1'b0;
                        r_s_be      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
